// File: rtl/timer0_pkg.sv
// Shared timer0 definitions: I/O register map, flag bit positions,
// clock-select and waveform-mode encodings, and interrupt vector numbers.
package timer0_pkg;

  // I/O register addresses
  localparam logic [5:0] TIFR_ADDR   = 6'h15;
  localparam logic [5:0] TCCR0A_ADDR = 6'h24;
  localparam logic [5:0] TCCR0B_ADDR = 6'h25;
  localparam logic [5:0] TCNT0_ADDR  = 6'h26;
  localparam logic [5:0] OCR0A_ADDR  = 6'h27;
  localparam logic [5:0] OCR0B_ADDR  = 6'h28;
  localparam logic [5:0] TIMSK_ADDR  = 6'h2E;

  // TIFR / TIMSK bit indices
  localparam int TOV0  = 0;
  localparam int OCF0A = 1;
  localparam int OCF0B = 2;

  // Clock-select encodings held in TCCR0B[2:0]
  typedef enum logic [2:0] {
    CS_STOP     = 3'b000,
    CS_DIV1     = 3'b001,
    CS_DIV8     = 3'b010,
    CS_DIV64    = 3'b011,
    CS_DIV256   = 3'b100,
    CS_DIV1024  = 3'b101,
    CS_EXT_FALL = 3'b110,
    CS_EXT_RISE = 3'b111
  } cs_t;

  // Waveform mode held in TCCR0A[1:0]; only CTC differs from Normal
  localparam logic [1:0] WGM_CTC = 2'b10;

  // Interrupt vectors serviced by this timer
  localparam logic [9:0] TIM0_COMPA_ISR = 10'd14;
  localparam logic [9:0] TIM0_COMPB_ISR = 10'd15;
  localparam logic [9:0] TIM0_OVF_ISR   = 10'd16;

  // Map an acknowledged vector onto the TIFR bit it clears
  function automatic logic [2:0] ack_clear_mask(input logic ack, input logic [9:0] vector);
    logic [2:0] mask;
    mask = 3'b000;
    if (ack) begin
      case (vector)
        TIM0_OVF_ISR:   mask = 3'b001;
        TIM0_COMPA_ISR: mask = 3'b010;
        TIM0_COMPB_ISR: mask = 3'b100;
        default:        mask = 3'b000;
      endcase
    end else begin
      mask = 3'b000;
    end
    return mask;
  endfunction

endpackage

// File: rtl/timer0_prescaler.sv
// Free-running 10-bit prescaler with clock-select decode; emits a
// single-cycle count enable for the timer.
module timer0_prescaler
  import timer0_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] cs,
  output logic       tick
);

  logic [9:0] psc_r;
  logic       tick_s;

  // Prescaler counts every clock and wraps naturally; only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_r <= 10'd0;
    end else begin
      psc_r <= psc_r + 10'd1;
    end
  end

  // Select the tick from the prescaler phase chosen by CS
  always_comb begin
    tick_s = 1'b0;
    case (cs)
      CS_DIV1:    tick_s = 1'b1;
      CS_DIV8:    tick_s = (psc_r[2:0] == 3'h7);
      CS_DIV64:   tick_s = (psc_r[5:0] == 6'h3F);
      CS_DIV256:  tick_s = (psc_r[7:0] == 8'hFF);
      CS_DIV1024: tick_s = (psc_r == 10'h3FF);
      default:    tick_s = 1'b0;
    endcase
  end

  assign tick = tick_s;

endmodule

// File: rtl/timer0_core.sv
// 8-bit Timer/Counter0: Normal and CTC modes, two compare units, TIFR
// flags with write-one-to-clear and vector-acknowledge clearing.
module timer0_core
  import timer0_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int I_ADDR_WIDTH  = 10,
  parameter int IO_ADDR_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     io_we,
  input  logic [IO_ADDR_WIDTH-1:0] io_addr,
  input  logic [DATA_WIDTH-1:0]    io_wdata,
  output logic [DATA_WIDTH-1:0]    io_rdata,
  input  logic                     irq_ack,
  input  logic [I_ADDR_WIDTH-1:0]  ack_vector,
  output logic [DATA_WIDTH-1:0]    mem_tifr,
  output logic [DATA_WIDTH-1:0]    mem_timsk,
  output logic [DATA_WIDTH-1:0]    tcnt
);

  localparam logic [DATA_WIDTH-1:0] CNT_MAX = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] tcnt_r;
  logic [DATA_WIDTH-1:0] ocr0a_r;
  logic [DATA_WIDTH-1:0] ocr0b_r;
  logic [DATA_WIDTH-1:0] tccr0a_r;
  logic [DATA_WIDTH-1:0] tccr0b_r;
  logic [2:0]            tifr_r;
  logic [2:0]            timsk_r;

  logic                  tick_s;
  logic                  tcnt_wr_s;
  logic                  tifr_wr_s;
  logic                  count_tick_s;
  logic                  ctc_s;
  logic [DATA_WIDTH-1:0] tcnt_next_s;
  logic [2:0]            flag_set_s;
  logic [2:0]            flag_clr_s;
  logic [2:0]            tifr_next_s;

  timer0_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .cs    (tccr0b_r[2:0]),
    .tick  (tick_s)
  );

  // Counter next value, hardware flag sets and flag clears for this cycle
  always_comb begin
    tcnt_wr_s    = io_we && (io_addr == TCNT0_ADDR);
    tifr_wr_s    = io_we && (io_addr == TIFR_ADDR);
    // A CPU write to TCNT0 swallows the tick: no count, no match, no overflow
    count_tick_s = tick_s && !tcnt_wr_s;
    ctc_s        = (tccr0a_r[1:0] == WGM_CTC);
    flag_set_s   = 3'b000;
    tcnt_next_s  = tcnt_r;

    if (count_tick_s) begin
      flag_set_s[TOV0]  = (tcnt_r == CNT_MAX);
      flag_set_s[OCF0A] = (tcnt_r == ocr0a_r);
      flag_set_s[OCF0B] = (tcnt_r == ocr0b_r);
    end else begin
      flag_set_s = 3'b000;
    end

    if (tcnt_wr_s) begin
      tcnt_next_s = io_wdata;
    end else if (count_tick_s) begin
      if (ctc_s && (tcnt_r == ocr0a_r)) begin
        tcnt_next_s = '0;
      end else begin
        tcnt_next_s = tcnt_r + CNT_ONE;
      end
    end else begin
      tcnt_next_s = tcnt_r;
    end

    flag_clr_s  = ack_clear_mask(irq_ack, ack_vector) |
                  (tifr_wr_s ? io_wdata[2:0] : 3'b000);
    // Hardware set takes precedence over any clear of the same bit
    tifr_next_s = (tifr_r & ~flag_clr_s) | flag_set_s;
  end

  // Register file, counter and flag state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_r   <= '0;
      ocr0a_r  <= '0;
      ocr0b_r  <= '0;
      tccr0a_r <= '0;
      tccr0b_r <= '0;
      tifr_r   <= 3'b000;
      timsk_r  <= 3'b000;
    end else begin
      tcnt_r <= tcnt_next_s;
      tifr_r <= tifr_next_s;
      if (io_we) begin
        case (io_addr)
          OCR0A_ADDR:  ocr0a_r  <= io_wdata;
          OCR0B_ADDR:  ocr0b_r  <= io_wdata;
          TCCR0A_ADDR: tccr0a_r <= io_wdata;
          TCCR0B_ADDR: tccr0b_r <= io_wdata;
          TIMSK_ADDR:  timsk_r  <= io_wdata[2:0];
          default:     ;
        endcase
      end
    end
  end

  // Combinational read mux; unowned addresses read as zero
  always_comb begin
    io_rdata = '0;
    case (io_addr)
      TCNT0_ADDR:  io_rdata = tcnt_r;
      OCR0A_ADDR:  io_rdata = ocr0a_r;
      OCR0B_ADDR:  io_rdata = ocr0b_r;
      TCCR0A_ADDR: io_rdata = tccr0a_r;
      TCCR0B_ADDR: io_rdata = tccr0b_r;
      TIFR_ADDR:   io_rdata = {{(DATA_WIDTH-3){1'b0}}, tifr_r};
      TIMSK_ADDR:  io_rdata = {{(DATA_WIDTH-3){1'b0}}, timsk_r};
      default:     io_rdata = '0;
    endcase
  end

  assign tcnt      = tcnt_r;
  assign mem_tifr  = {{(DATA_WIDTH-3){1'b0}}, tifr_r};
  assign mem_timsk = {{(DATA_WIDTH-3){1'b0}}, timsk_r};

endmodule

// File: tb/tb_timer0_core.sv
// Scoreboard bench for timer0_core: a behavioural model predicts the state
// after every clock, a monitor compares it against the DUT.
module tb_timer0_core;
  import timer0_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       io_we = 1'b0;
  logic [5:0] io_addr = 6'd0;
  logic [7:0] io_wdata = 8'd0;
  logic [7:0] io_rdata;
  logic       irq_ack = 1'b0;
  logic [9:0] ack_vector = 10'd0;
  logic [7:0] mem_tifr;
  logic [7:0] mem_timsk;
  logic [7:0] tcnt;

  always #5 clk = ~clk;

  timer0_core dut (
    .clk        (clk),
    .reset      (reset),
    .io_we      (io_we),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .irq_ack    (irq_ack),
    .ack_vector (ack_vector),
    .mem_tifr   (mem_tifr),
    .mem_timsk  (mem_timsk),
    .tcnt       (tcnt)
  );

  typedef struct packed {
    logic [7:0] tcnt;
    logic [7:0] tifr;
    logic [7:0] timsk;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int         m_psc;
  logic [7:0] m_tcnt, m_ocra, m_ocrb, m_tccra, m_tccrb, m_timsk;
  logic [2:0] m_tifr;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_psc = 0; m_tcnt = 8'd0; m_ocra = 8'd0; m_ocrb = 8'd0;
    m_tccra = 8'd0; m_tccrb = 8'd0; m_timsk = 8'd0; m_tifr = 3'd0;
  endtask

  function automatic logic [7:0] m_read(input logic [5:0] a);
    case (a)
      TCNT0_ADDR:  return m_tcnt;
      OCR0A_ADDR:  return m_ocra;
      OCR0B_ADDR:  return m_ocrb;
      TCCR0A_ADDR: return m_tccra;
      TCCR0B_ADDR: return m_tccrb;
      TIFR_ADDR:   return {5'd0, m_tifr};
      TIMSK_ADDR:  return m_timsk;
      default:     return 8'd0;
    endcase
  endfunction

  // Drive one cycle of inputs (called at a falling edge), advance the model
  // over the coming rising edge, queue the expectation, return at next fall.
  task automatic step(input logic we, input logic [5:0] addr, input logic [7:0] wd,
                      input logic ack, input logic [9:0] vec);
    int         div;
    bit         tk;
    logic [2:0] set_m, clr_m;
    logic [7:0] cnt_n;
    exp_t       e;
    io_we = we; io_addr = addr; io_wdata = wd; irq_ack = ack; ack_vector = vec;
    case (m_tccrb[2:0])
      3'd1:    div = 1;
      3'd2:    div = 8;
      3'd3:    div = 64;
      3'd4:    div = 256;
      3'd5:    div = 1024;
      default: div = 0;
    endcase
    tk = (div != 0) && ((m_psc % div) == div - 1);
    set_m = 3'd0;
    cnt_n = m_tcnt;
    if (we && addr == TCNT0_ADDR) begin
      cnt_n = wd;
    end else if (tk) begin
      if (m_tcnt == 8'hFF) set_m[0] = 1'b1;
      if (m_tcnt == m_ocra) set_m[1] = 1'b1;
      if (m_tcnt == m_ocrb) set_m[2] = 1'b1;
      if (m_tccra[1:0] == 2'b10 && m_tcnt == m_ocra) cnt_n = 8'd0;
      else cnt_n = m_tcnt + 8'd1;
    end
    clr_m = 3'd0;
    if (we && addr == TIFR_ADDR) clr_m = wd[2:0];
    if (ack) begin
      if (vec == TIM0_OVF_ISR) clr_m[0] = 1'b1;
      if (vec == TIM0_COMPA_ISR) clr_m[1] = 1'b1;
      if (vec == TIM0_COMPB_ISR) clr_m[2] = 1'b1;
    end
    m_tifr = (m_tifr & ~clr_m) | set_m;
    m_tcnt = cnt_n;
    if (we) begin
      case (addr)
        OCR0A_ADDR:  m_ocra  = wd;
        OCR0B_ADDR:  m_ocrb  = wd;
        TCCR0A_ADDR: m_tccra = wd;
        TCCR0B_ADDR: m_tccrb = wd;
        TIMSK_ADDR:  m_timsk = {5'd0, wd[2:0]};
        default:     ;
      endcase
    end
    m_psc = (m_psc + 1) % 1024;
    e.tcnt = m_tcnt; e.tifr = {5'd0, m_tifr}; e.timsk = m_timsk; e.rdata = m_read(addr);
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    step(1'b1, a, d, 1'b0, 10'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'($urandom_range(0, 63)), 8'd0, 1'b0, 10'd0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once
  task automatic mid_reset();
    io_we = 1'b0; irq_ack = 1'b0; io_addr = TCCR0B_ADDR;
    #2 reset = 1'b1;
    #1;
    cmp("rst_tcnt", 32'(tcnt), 32'd0);
    cmp("rst_tifr", 32'(mem_tifr), 32'd0);
    cmp("rst_timsk", 32'(mem_timsk), 32'd0);
    cmp("rst_rdata", 32'(io_rdata), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  // Monitor: compare the DUT against the oldest expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp("tcnt", 32'(tcnt), 32'(e.tcnt));
        cmp("tifr", 32'(mem_tifr), 32'(e.tifr));
        cmp("timsk", 32'(mem_timsk), 32'(e.timsk));
        cmp("rdata", 32'(io_rdata), 32'(e.rdata));
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    logic [5:0] owned [7];
    int         r, k;
    logic       we, ack;
    logic [5:0] a;
    logic [7:0] d;
    logic [9:0] v;
    owned = '{TCNT0_ADDR, OCR0A_ADDR, OCR0B_ADDR, TCCR0A_ADDR, TCCR0B_ADDR, TIFR_ADDR, TIMSK_ADDR};
    m_reset();
    #1 reset = 1'b1;
    #1;
    cmp("init_tcnt", 32'(tcnt), 32'd0);
    cmp("init_tifr", 32'(mem_tifr), 32'd0);
    cmp("init_timsk", 32'(mem_timsk), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Normal mode overflow FD -> FE -> FF -> 00
    wr(TCCR0B_ADDR, 8'h01);
    wr(TCNT0_ADDR, 8'hFD);
    idle(6);
    wr(TIMSK_ADDR, 8'hFF);

    // CTC with OCR0A=4
    wr(TCCR0B_ADDR, 8'h00);
    wr(TIFR_ADDR, 8'h07);
    wr(TCNT0_ADDR, 8'h00);
    wr(OCR0A_ADDR, 8'h04);
    wr(TCCR0A_ADDR, 8'h02);
    wr(TCCR0B_ADDR, 8'h01);
    idle(15);

    // Reset mid-count, then divide-by-8 from reset
    mid_reset();
    wr(TCCR0B_ADDR, 8'h02);
    idle(30);

    // OCF0B set, then cleared by vector acknowledge
    wr(TCCR0B_ADDR, 8'h00);
    wr(TIFR_ADDR, 8'h07);
    wr(OCR0B_ADDR, 8'h03);
    wr(TCNT0_ADDR, 8'hFE);
    wr(TCCR0B_ADDR, 8'h01);
    idle(6);
    step(1'b0, TIFR_ADDR, 8'h00, 1'b1, TIM0_COMPB_ISR);
    idle(2);

    // TIFR clear colliding with TOV0 set, then a plain clear
    wr(TCNT0_ADDR, 8'hFE);
    idle(1);
    wr(TIFR_ADDR, 8'h01);
    idle(2);
    wr(TIFR_ADDR, 8'h01);
    idle(2);

    // TCNT0 write on a matching tick suppresses OCF0A
    wr(TCCR0A_ADDR, 8'h00);
    wr(OCR0A_ADDR, 8'h20);
    wr(TCNT0_ADDR, 8'h1F);
    wr(TIFR_ADDR, 8'h07);
    wr(TCNT0_ADDR, 8'h10);
    idle(3);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom_range(0, 99);
      we = (r < 10);
      a  = we ? owned[$urandom_range(0, 6)] : 6'($urandom_range(0, 63));
      d  = 8'($urandom);
      if (we && a == TCCR0B_ADDR) begin
        k = $urandom_range(0, 9);
        if (k < 5) d[2:0] = 3'd1;
        else if (k == 5) d[2:0] = 3'd2;
        else if (k == 6) d[2:0] = 3'd3;
        else if (k == 7) d[2:0] = 3'd0;
        else if (k == 8) d[2:0] = 3'd4;
        else d[2:0] = 3'($urandom_range(5, 7));
      end
      ack = ($urandom_range(0, 7) == 0);
      k   = $urandom_range(0, 3);
      v   = (k == 0) ? TIM0_OVF_ISR : (k == 1) ? TIM0_COMPA_ISR :
            (k == 2) ? TIM0_COMPB_ISR : 10'($urandom_range(0, 1023));
      step(we, a, d, ack, v);
    end

    mid_reset();
    idle(4);
    @(posedge clk);
    #2;
    cmp("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
